// File: rtl/aes_encryption.sv
// Iterative AES-128 encryption core: one load cycle and then one round per clock.
// Round keys are expanded on the fly, and the finished ciphertext is held in dataout.
module aes_encryption (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] plain_text,
    input  logic [127:0] c_key,
    output logic [127:0] dataout,
    output logic         done
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i*8 +: 8] = sbox(s[i*8 +: 8]);
        end
        return r;
    endfunction

    // Byte n of the state sits at bits [127-8n -: 8]; n = row + 4*column.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] dataout_q, dataout_d;
    logic         done_q, done_d;

    logic [127:0] sr_state;
    logic [127:0] mc_state;
    logic [127:0] next_key;
    logic [31:0]  rot_w3;
    logic [31:0]  key_temp;
    logic [31:0]  nw0, nw1, nw2, nw3;

    always_comb begin
        sr_state = shift_rows(sub_bytes(state_q));
        mc_state = mix_columns(sr_state);

        rot_w3   = {key_q[23:0], key_q[31:24]};
        key_temp = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                    sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])} ^ {rcon(rnd_q), 24'h0};
        nw0      = key_q[127:96] ^ key_temp;
        nw1      = key_q[95:64]  ^ nw0;
        nw2      = key_q[63:32]  ^ nw1;
        nw3      = key_q[31:0]   ^ nw2;
        next_key = {nw0, nw1, nw2, nw3};
    end

    always_comb begin
        rnd_d     = rnd_q;
        state_d   = state_q;
        key_d     = key_q;
        dataout_d = dataout_q;
        done_d    = 1'b0;

        if (rnd_q == 4'd0) begin
            state_d = plain_text ^ c_key;
            key_d   = c_key;
            rnd_d   = 4'd1;
        end else if (rnd_q < 4'd10) begin
            state_d = mc_state ^ next_key;
            key_d   = next_key;
            rnd_d   = rnd_q + 4'd1;
        end else if (rnd_q == 4'd10) begin
            dataout_d = sr_state ^ next_key;
            done_d    = 1'b1;
            rnd_d     = 4'd0;
        end else begin
            // Unreachable counter codes fall back to a fresh load.
            rnd_d = 4'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rnd_q     <= 4'd0;
            state_q   <= '0;
            key_q     <= '0;
            dataout_q <= '0;
            done_q    <= 1'b0;
        end else begin
            rnd_q     <= rnd_d;
            state_q   <= state_d;
            key_q     <= key_d;
            dataout_q <= dataout_d;
            done_q    <= done_d;
        end
    end

    assign dataout = dataout_q;
    assign done    = done_q;

endmodule

// File: tb/tb_aes_encryption.sv
// Directed-vector bench for aes_encryption using known FIPS-197 and ASCII answers,
// including a mid-operation input change and an asynchronous reset mid-encryption.
module tb_aes_encryption;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A_PT   = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] A_KEY  = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] A_CT   = 128'h29c3505f571420f6402299b31a02d73a;

    logic         clock;
    logic         reset;
    logic [127:0] plain_text;
    logic [127:0] c_key;
    logic [127:0] dataout;
    logic         done;

    int vectors_applied;
    int miscompares;
    int latency;

    aes_encryption dut (
        .clock      (clock),
        .reset      (reset),
        .plain_text (plain_text),
        .c_key      (c_key),
        .dataout    (dataout),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key);
        plain_text = pt;
        c_key      = key;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Returns how many edges passed before done was seen, or -1 if it never came.
    task automatic waitDone(input int max_edges, output int edges);
        edges = -1;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        reset           = 1'b1;
        applyStimulus(C1_PT, C1_KEY);
        #3;
        checkOutput("reset_dataout", dataout, 128'h0);
        checkOutput("reset_done", 128'(done), 128'h0);

        @(negedge clock);
        reset = 1'b0;
        waitDone(20, latency);
        checkOutput("c1_latency", 128'(latency), 128'd11);
        checkOutput("c1_dataout", dataout, C1_CT);

        tick(1);
        checkOutput("c1_done_single", 128'(done), 128'h0);
        checkOutput("c1_dataout_hold", dataout, C1_CT);

        tick(3);
        applyStimulus(B_PT, B_KEY);
        waitDone(20, latency);
        checkOutput("midchange_latency", 128'(latency), 128'd7);
        checkOutput("midchange_c1_first", dataout, C1_CT);

        tick(2);
        checkOutput("appb_round1_state", dut.state_q, B_R1);
        tick(8);
        checkOutput("appb_round10_key", dut.next_key, B_K10);
        waitDone(20, latency);
        checkOutput("appb_latency", 128'(latency), 128'd1);
        checkOutput("appb_dataout", dataout, B_CT);

        applyStimulus(A_PT, A_KEY);
        waitDone(20, latency);
        checkOutput("ascii_latency", 128'(latency), 128'd11);
        checkOutput("ascii_dataout", dataout, A_CT);

        tick(5);
        applyStimulus(B_PT, B_KEY);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_dataout", dataout, 128'h0);
        checkOutput("midreset_done", 128'(done), 128'h0);
        @(negedge clock);
        reset = 1'b0;
        waitDone(20, latency);
        checkOutput("postreset_latency", 128'(latency), 128'd11);
        checkOutput("postreset_dataout", dataout, B_CT);
        tick(1);
        checkOutput("postreset_done_single", 128'(done), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
